// File: rtl/sign_compress_ser.sv
// sign_compress_ser: packs 32-bit words into a 16-bit stream, sending sign-extendable words as one short beat
module sign_compress_ser #(
    parameter int HALF_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2*HALF_W-1:0]   data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [HALF_W-1:0]     data_o,
    output logic                  short_o,
    output logic                  last_o,
    output logic [CNT_W-1:0]      long_cnt_o
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] LO    = 2'd2;
    localparam logic [1:0] HI    = 2'd3;
    logic [1:0]          state;
    logic [1:0]          state_nx;
    logic [2*HALF_W-1:0] word;
    logic                comp;
    logic                in_xfer;
    logic                out_xfer;
    assign comp        = data_i[2*HALF_W-1:HALF_W] == {HALF_W{data_i[HALF_W-1]}};
    assign out_valid_o = state != EMPTY;
    assign short_o     = state == ONE;
    assign last_o      = state == ONE || state == HI;
    assign data_o      = state == HI ? word[2*HALF_W-1:HALF_W] : word[HALF_W-1:0];
    assign out_xfer    = out_valid_o && out_ready_i;
    assign in_ready_o  = state == EMPTY || (out_xfer && last_o);
    assign in_xfer     = in_valid_i && in_ready_o;
    // a newly accepted word takes priority; otherwise a taken beat advances LO->HI or drains to EMPTY
    always_comb
        state_nx = in_xfer ? (comp ? ONE : LO) : !out_xfer ? state : state == LO ? HI : EMPTY;
    // state, word holding register and saturating long-word counter
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= EMPTY;
            word       <= '0;
            long_cnt_o <= '0;
        end else begin
            state <= state_nx;
            if (in_xfer)
                word <= data_i;
            if (in_xfer && !comp && long_cnt_o != '1)
                long_cnt_o <= long_cnt_o + 1'b1;
        end
    end
endmodule
